// File: rtl/snake_turn_queue.sv
// snake_turn_queue
//   Turn-request buffer between the PS/2 decoder and the snake engine.
//   Arrow-key make pulses are queued and then applied to the committed heading
//   at most one per game move tick. This means quick double-taps are kept
//   rather than overwritten. Reversals and repeats of the reference heading
//   are rejected.
//
// Parameters
//   DEPTH     turn FIFO depth, 1..4
//   INIT_DIR  heading after reset and while the game is idle
//
// Ports
//   CLOCK_50       in   system clock
//   resetn         in   asynchronous, active-low reset
//   up_pulse       in   one-cycle make pulse (highest priority)
//   down_pulse     in   one-cycle make pulse
//   left_pulse     in   one-cycle make pulse
//   right_pulse    in   one-cycle make pulse (lowest priority)
//   move_tick      in   one-cycle strobe, the snake advances one cell
//   game_started   in   level, 0 = attract/idle (queue flushed)
//   dir            out  committed heading: 00 right, 01 left, 10 up, 11 down
//   q_count        out  number of queued turns, 0..DEPTH
//   turn_rejected  out  pulse: request was a reversal or a duplicate
//   turn_dropped   out  pulse: request was legal but the queue was full

module snake_turn_queue #(
  parameter int         DEPTH    = 2,
  parameter logic [1:0] INIT_DIR = 2'b00
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       up_pulse,
  input  logic       down_pulse,
  input  logic       left_pulse,
  input  logic       right_pulse,
  input  logic       move_tick,
  input  logic       game_started,
  output logic [1:0] dir,
  output logic [2:0] q_count,
  output logic       turn_rejected,
  output logic       turn_dropped
);

  localparam logic [1:0] DirRight = 2'b00;
  localparam logic [1:0] DirLeft  = 2'b01;
  localparam logic [1:0] DirUp    = 2'b10;
  localparam logic [1:0] DirDown  = 2'b11;

  localparam logic [2:0] DepthC  = 3'(DEPTH);
  localparam logic [1:0] LastPtr = 2'(DEPTH - 1);

  // Storage is always four entries wide so a 2-bit pointer indexes it cleanly.
  // Only the first DEPTH entries are ever used.
  logic [1:0] fifo_q [4];
  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;
  logic [1:0] dir_q, dir_d;
  logic       rej_q, rej_d;
  logic       drop_q, drop_d;

  logic       reqValid;
  logic [1:0] reqDir;
  logic [1:0] tailLast;
  logic [1:0] refDir;
  logic       legal;
  logic       popEn;
  logic       pushEn;
  logic       dropEn;

  function automatic logic [1:0] nextPtr(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  // This block decodes the request and decides what happens to it.
  // The reference heading is the most recently queued turn, or the committed
  // heading if nothing is queued. Both are taken from the registered state,
  // so a pop in the same cycle cannot affect the reference.
  // A pop in the same cycle frees a slot, so a legal push into a full queue
  // still succeeds.
  always_comb begin
    reqValid = up_pulse | down_pulse | left_pulse | right_pulse;
    reqDir   = DirRight;
    if (up_pulse)        reqDir = DirUp;
    else if (down_pulse) reqDir = DirDown;
    else if (left_pulse) reqDir = DirLeft;

    tailLast = (tail_q == 2'd0) ? LastPtr : tail_q - 2'd1;
    refDir   = (count_q != 3'd0) ? fifo_q[tailLast] : dir_q;
    // Bit 1 separates horizontal from vertical headings, so a differing
    // bit 1 means the request is perpendicular to the reference.
    legal    = reqDir[1] != refDir[1];

    popEn  = move_tick && (count_q != 3'd0);
    pushEn = reqValid && legal && ((count_q < DepthC) || popEn);
    dropEn = reqValid && legal && (count_q == DepthC) && !popEn;
  end

  // This block computes the next state. While the game is idle the queue is
  // flushed, the heading is parked, and any activity in that cycle is ignored.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    dir_d   = dir_q;
    rej_d   = 1'b0;
    drop_d  = 1'b0;

    if (!game_started) begin
      head_d  = 2'd0;
      tail_d  = 2'd0;
      count_d = 3'd0;
      dir_d   = INIT_DIR;
    end else begin
      rej_d  = reqValid && !legal;
      drop_d = dropEn;
      if (popEn) begin
        dir_d  = fifo_q[head_q];
        head_d = nextPtr(head_q);
      end
      if (pushEn) begin
        tail_d = nextPtr(tail_q);
      end
      case ({pushEn, popEn})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // This block holds the state registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
      dir_q   <= INIT_DIR;
      rej_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      rej_q   <= rej_d;
      drop_q  <= drop_d;
    end
  end

  // This block holds the turn storage. An entry is written only on an
  // accepted push.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= INIT_DIR;
    end else if (game_started && pushEn) begin
      fifo_q[tail_q] <= reqDir;
    end
  end

  assign dir           = dir_q;
  assign q_count       = count_q;
  assign turn_rejected = rej_q;
  assign turn_dropped  = drop_q;

endmodule

// File: tb/tb_snake_turn_queue.sv
// tb_snake_turn_queue
//   Testbench for snake_turn_queue. The driver applies one cycle of inputs
//   at a time and advances a queue-based reference model of the turn buffer.
//   It then pushes the outputs expected after the next clock edge onto a
//   scoreboard. A separate monitor pops one entry after every rising edge
//   and compares it against the design outputs.

module tb_snake_turn_queue;

  localparam int         DEPTH    = 2;
  localparam logic [1:0] INIT_DIR = 2'b00;
  localparam logic [1:0] RIGHT = 2'b00;
  localparam logic [1:0] LEFT  = 2'b01;
  localparam logic [1:0] UP    = 2'b10;
  localparam logic [1:0] DOWN  = 2'b11;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       up_pulse = 1'b0;
  logic       down_pulse = 1'b0;
  logic       left_pulse = 1'b0;
  logic       right_pulse = 1'b0;
  logic       move_tick = 1'b0;
  logic       game_started = 1'b0;
  logic [1:0] dir;
  logic [2:0] q_count;
  logic       turn_rejected;
  logic       turn_dropped;

  snake_turn_queue #(.DEPTH(DEPTH), .INIT_DIR(INIT_DIR)) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .up_pulse     (up_pulse),
    .down_pulse   (down_pulse),
    .left_pulse   (left_pulse),
    .right_pulse  (right_pulse),
    .move_tick    (move_tick),
    .game_started (game_started),
    .dir          (dir),
    .q_count      (q_count),
    .turn_rejected(turn_rejected),
    .turn_dropped (turn_dropped)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [1:0] dir;
    logic [2:0] cnt;
    logic       rej;
    logic       drop;
  } expect_t;

  expect_t    expQ[$];
  int         checks = 0;
  int         errors = 0;
  bit         driverDone = 1'b0;

  // Reference model: a plain list of pending headings plus the committed one.
  logic [1:0] mQueue[$];
  logic [1:0] mDir = INIT_DIR;
  logic       mRej = 1'b0;
  logic       mDrop = 1'b0;

  function automatic bit isVertical(input logic [1:0] h);
    return (h == UP) || (h == DOWN);
  endfunction

  task automatic checkOutput(input string name, input expect_t e);
    checks++;
    if (dir !== e.dir || q_count !== e.cnt || turn_rejected !== e.rej || turn_dropped !== e.drop) begin
      errors++;
      $display("[TB] FAIL %s t=%0t: got dir=%b q_count=%0d rej=%b drop=%b, expected dir=%b q_count=%0d rej=%b drop=%b",
               name, $time, dir, q_count, turn_rejected, turn_dropped, e.dir, e.cnt, e.rej, e.drop);
    end
  endtask

  // Advance the model by one clock edge for the given inputs.
  task automatic modelStep(input bit rstn, input bit gs, input bit u, input bit d,
                           input bit l, input bit r, input bit tick);
    logic [1:0] req;
    logic [1:0] refH;
    bit         any;
    bit         popNow;
    if (!rstn) begin
      mQueue.delete();
      mDir = INIT_DIR; mRej = 0; mDrop = 0;
    end else if (!gs) begin
      mQueue.delete();
      mDir = INIT_DIR; mRej = 0; mDrop = 0;
    end else begin
      any = u || d || l || r;
      req = u ? UP : d ? DOWN : l ? LEFT : RIGHT;
      refH = (mQueue.size() > 0) ? mQueue[$] : mDir;
      popNow = tick && (mQueue.size() > 0);
      mRej = 0; mDrop = 0;
      if (popNow) mDir = mQueue.pop_front();
      if (any) begin
        if (isVertical(req) == isVertical(refH)) mRej = 1;
        else if (mQueue.size() < DEPTH) mQueue.push_back(req);
        else mDrop = 1;
      end
    end
  endtask

  // Drive one cycle, starting just after a falling edge, and record what
  // the outputs should be after the coming rising edge.
  task automatic applyStimulus(input bit rstn, input bit gs, input bit u, input bit d,
                               input bit l, input bit r, input bit tick);
    expect_t e;
    resetn = rstn; game_started = gs;
    up_pulse = u; down_pulse = d; left_pulse = l; right_pulse = r;
    move_tick = tick;
    modelStep(rstn, gs, u, d, l, r, tick);
    e.dir = mDir; e.cnt = 3'(mQueue.size()); e.rej = mRej; e.drop = mDrop;
    expQ.push_back(e);
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic tick1();
    applyStimulus(1, 1, 0, 0, 0, 0, 1);
  endtask

  // Pull reset between clock edges and confirm the outputs clear at once.
  task automatic asyncResetCheck();
    expect_t e;
    #3;
    resetn = 1'b0;
    #1;
    e.dir = INIT_DIR; e.cnt = 0; e.rej = 0; e.drop = 0;
    checkOutput("async_reset", e);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: after each rising edge, compare the design with the next
  // expected entry.
  initial begin
    expect_t e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("cycle", e);
      end
    end
  end

  initial begin
    int cycles;
    bit gsState;
    @(negedge CLOCK_50);

    // Reset, then three empty ticks.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    repeat (3) begin tick1(); idle(1); end

    // Basic turn.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    idle(9);
    tick1();
    idle(2);

    // Double tap, then three ticks.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    idle(1);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    idle(1);
    repeat (3) begin tick1(); idle(1); end

    // Rejects: reversal, duplicate, reversal of the queued tail.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    idle(1);
    applyStimulus(1, 1, 0, 0, 0, 1, 0);
    idle(1);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    idle(1);

    // Full queue: drop, then push coincident with a pop.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 0, 1, 0, 0, 0);
    idle(1);
    applyStimulus(1, 1, 0, 1, 0, 0, 1);
    idle(1);

    // Priority, then idle flush with two turns queued.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 1, 0, 1);
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset with turns pending.
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    asyncResetCheck();
    applyStimulus(1, 1, 0, 0, 0, 0, 0);

    // Randomized play.
    gsState = 1;
    cycles = 0;
    while (cycles < 3000) begin
      bit u, d, l, r, t, rst;
      if ($urandom_range(0, 99) < 2) gsState = ~gsState;
      u = ($urandom_range(0, 99) < 12);
      d = ($urandom_range(0, 99) < 12);
      l = ($urandom_range(0, 99) < 12);
      r = ($urandom_range(0, 99) < 12);
      t = ($urandom_range(0, 99) < 20);
      rst = ($urandom_range(0, 999) < 3);
      applyStimulus(!rst, gsState, u, d, l, r, t);
      cycles++;
    end

    idle(2);
    driverDone = 1'b1;
    @(posedge CLOCK_50);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit in case the run stalls.
  initial begin
    #2000000;
    if (!driverDone) begin
      $display("[TB] FAIL timeout: got no completion, expected completion before limit");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
